// File: rtl/galois_lfsr_gen.sv
// Parametrised Galois LFSR source with reseed handshake, output stall, zero-load
// substitution and measured period between the start value and its recurrence.
module galois_lfsr_gen #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
  parameter logic [WIDTH-1:0] SEED  = 16'h0400
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_lfsr,
  output logic             out_bit,
  output logic             zero_fix,
  output logic             wrap,
  output logic [WIDTH-1:0] period
);

  typedef enum logic {INIT, RUN} fsm_t;

  fsm_t             fsm;
  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] start;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] step_next;

  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : '0);
  endfunction

  function automatic logic [WIDTH-1:0] nonzero_load(input logic [WIDTH-1:0] d);
    return (d == '0) ? SEED : d;
  endfunction

  assign step_next = lfsr_next(state);
  assign out_lfsr  = state;
  assign out_bit   = state[0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm        <= INIT;
      state      <= '0;
      start      <= '0;
      cnt        <= '0;
      period     <= '0;
      out_valid  <= 1'b0;
      load_ready <= 1'b0;
      zero_fix   <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      zero_fix <= 1'b0;
      wrap     <= 1'b0;
      case (fsm)
        INIT: begin
          state      <= SEED;
          start      <= SEED;
          cnt        <= '0;
          out_valid  <= 1'b1;
          load_ready <= 1'b1;
          fsm        <= RUN;
        end
        default: begin
          // A reseed outranks a step issued in the same cycle.
          if (load_valid && load_ready) begin
            state    <= nonzero_load(load_data);
            start    <= nonzero_load(load_data);
            cnt      <= '0;
            zero_fix <= (load_data == '0);
          end else if (en && out_ready) begin
            state <= step_next;
            if (step_next == start) begin
              wrap   <= 1'b1;
              period <= cnt + 1'b1;
              cnt    <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_galois_lfsr_gen.sv
// Randomised scoreboard bench for galois_lfsr_gen: default 16-bit instance plus a
// 4-bit instance, each tracked by a step-by-step behavioural model.
module tb_galois_lfsr_gen;

  typedef struct {
    bit          run;
    int unsigned state;
    int unsigned start;
    int unsigned steps;
    int unsigned period;
    bit          zf;
    bit          wrap;
  } mdl_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // 16-bit default instance
  logic        rst0 = 1'b0, en0 = 1'b0, lv0 = 1'b0, ordy0 = 1'b0;
  logic [15:0] ld0 = '0;
  logic        lrdy0, ovld0, obit0, zf0, wrap0;
  logic [15:0] lfsr0, per0;

  galois_lfsr_gen dut0 (
    .clk(clk), .rst(rst0), .en(en0), .load_valid(lv0), .load_data(ld0),
    .load_ready(lrdy0), .out_ready(ordy0), .out_valid(ovld0), .out_lfsr(lfsr0),
    .out_bit(obit0), .zero_fix(zf0), .wrap(wrap0), .period(per0)
  );

  // 4-bit instance, x^4+x^3+1
  logic       rst1 = 1'b0, en1 = 1'b0, lv1 = 1'b0, ordy1 = 1'b0;
  logic [3:0] ld1 = '0;
  logic       lrdy1, ovld1, obit1, zf1, wrap1;
  logic [3:0] lfsr1, per1;

  galois_lfsr_gen #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1)) dut1 (
    .clk(clk), .rst(rst1), .en(en1), .load_valid(lv1), .load_data(ld1),
    .load_ready(lrdy1), .out_ready(ordy1), .out_valid(ovld1), .out_lfsr(lfsr1),
    .out_bit(obit1), .zero_fix(zf1), .wrap(wrap1), .period(per1)
  );

  mdl_t m0, m1;
  mdl_t q0[$];
  mdl_t q1[$];

  // Reference: advance the abstract generator by one clock edge.
  function automatic mdl_t mstep(mdl_t m, bit r, bit e, bit lv, int unsigned ld, bit o,
                                 int w, int unsigned taps, int unsigned seed);
    int unsigned mask;
    int unsigned d;
    int unsigned nxt;
    mdl_t n;
    mask = (32'd1 << w) - 1;
    n = m;
    n.zf = 1'b0;
    n.wrap = 1'b0;
    if (!r) begin
      n = '{default: 0};
    end else if (!m.run) begin
      n.run = 1'b1;
      n.state = seed;
      n.start = seed;
      n.steps = 0;
    end else if (lv) begin
      d = ld & mask;
      n.state = (d == 0) ? seed : d;
      n.start = n.state;
      n.steps = 0;
      n.zf = (d == 0);
    end else if (e && o) begin
      nxt = (m.state % 2 == 1) ? ((m.state / 2) ^ taps) : (m.state / 2);
      n.state = nxt;
      n.steps = m.steps + 1;
      if (nxt == m.start) begin
        n.wrap = 1'b1;
        n.period = n.steps & mask;
        n.steps = 0;
      end
    end
    return n;
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive0(input bit r, input bit e, input bit lv, input int unsigned ld, input bit o);
    @(negedge clk);
    rst0 = r; en0 = e; lv0 = lv; ld0 = ld[15:0]; ordy0 = o;
    m0 = mstep(m0, r, e, lv, ld, o, 16, 32'hB400, 32'h0400);
    q0.push_back(m0);
  endtask

  task automatic drive1(input bit r, input bit e, input bit lv, input int unsigned ld, input bit o);
    @(negedge clk);
    rst1 = r; en1 = e; lv1 = lv; ld1 = ld[3:0]; ordy1 = o;
    m1 = mstep(m1, r, e, lv, ld, o, 4, 32'hC, 32'h1);
    q1.push_back(m1);
  endtask

  task automatic settle;
    @(posedge clk);
    #2;
  endtask

  always begin
    mdl_t x;
    @(posedge clk);
    #1;
    if (q0.size() > 0) begin
      x = q0.pop_front();
      checks++;
      if ({ovld0, lrdy0, zf0, wrap0, obit0, lfsr0, per0} !==
          {x.run, x.run, x.zf, x.wrap, x.state[0], x.state[15:0], x.period[15:0]}) begin
        failures++;
        $display("FAIL sb16: got v=%b r=%b zf=%b w=%b b=%b s=%h p=%h expected v=%b r=%b zf=%b w=%b b=%b s=%h p=%h",
                 ovld0, lrdy0, zf0, wrap0, obit0, lfsr0, per0,
                 x.run, x.run, x.zf, x.wrap, x.state[0], x.state[15:0], x.period[15:0]);
      end
      if (ovld0 === 1'b1) chk("nonzero16", (lfsr0 != 16'h0), 1);
    end
  end

  always begin
    mdl_t x;
    @(posedge clk);
    #1;
    if (q1.size() > 0) begin
      x = q1.pop_front();
      checks++;
      if ({ovld1, lrdy1, zf1, wrap1, obit1, lfsr1, per1} !==
          {x.run, x.run, x.zf, x.wrap, x.state[0], x.state[3:0], x.period[3:0]}) begin
        failures++;
        $display("FAIL sb4: got v=%b r=%b zf=%b w=%b b=%b s=%h p=%h expected v=%b r=%b zf=%b w=%b b=%b s=%h p=%h",
                 ovld1, lrdy1, zf1, wrap1, obit1, lfsr1, per1,
                 x.run, x.run, x.zf, x.wrap, x.state[0], x.state[3:0], x.period[3:0]);
      end
    end
  end

  task automatic stim0;
    bit r, e, lv, o;
    int unsigned ld;
    drive0(0, 1, 0, 0, 1);
    drive0(0, 1, 0, 0, 1);
    settle;
    chk("rst_lfsr", lfsr0, 16'h0000);
    chk("rst_valid", ovld0, 0);
    drive0(1, 1, 0, 0, 1);
    settle;
    chk("init_seed", lfsr0, 16'h0400);
    drive0(1, 1, 0, 0, 1);
    settle;
    chk("step1", lfsr0, 16'h0200);
    drive0(1, 1, 0, 0, 1);
    settle;
    chk("step2", lfsr0, 16'h0100);
    drive0(1, 1, 1, 16'h0001, 1);
    settle;
    chk("load_wins", lfsr0, 16'h0001);
    drive0(1, 1, 0, 0, 1);
    settle;
    chk("fb1", lfsr0, 16'hB400);
    drive0(1, 1, 0, 0, 1);
    settle;
    chk("fb2", lfsr0, 16'h5A00);
    drive0(1, 1, 0, 0, 1);
    settle;
    chk("fb3", lfsr0, 16'h2D00);
    drive0(1, 1, 1, 16'h0000, 1);
    settle;
    chk("zero_load", lfsr0, 16'h0400);
    chk("zero_fix_on", zf0, 1);
    drive0(1, 1, 0, 0, 1);
    settle;
    chk("zero_fix_off", zf0, 0);
    for (int i = 0; i < 1500; i++) begin
      r  = ($urandom_range(99) != 0);
      lv = ($urandom_range(19) == 0);
      ld = ($urandom_range(3) == 0) ? 0 : $urandom;
      e  = ($urandom_range(4) != 0);
      o  = ($urandom_range(4) != 0);
      drive0(r, e, lv, ld, o);
    end
    drive0(1, 1, 0, 0, 1);
    drive0(0, 1, 0, 0, 1);
    settle;
    chk("midrst_lfsr", lfsr0, 16'h0000);
    chk("midrst_period", per0, 16'h0000);
    drive0(1, 1, 0, 0, 1);
    settle;
    chk("midrst_seed", lfsr0, 16'h0400);
    drive0(1, 1, 1, 16'h1234, 1);
    for (int i = 0; i < 65535; i++) drive0(1, 1, 0, 0, 1);
    settle;
    chk("full_wrap", wrap0, 1);
    chk("full_period", per0, 16'hFFFF);
    chk("full_state", lfsr0, 16'h1234);
  endtask

  task automatic stim1;
    int unsigned held;
    drive1(0, 1, 0, 0, 1);
    drive1(0, 1, 0, 0, 1);
    for (int i = 0; i < 31; i++) drive1(1, 1, 0, 0, 1);
    settle;
    chk("p4_period", per1, 15);
    chk("p4_wrap", wrap1, 1);
    chk("p4_state", lfsr1, 4'h1);
    drive1(1, 1, 0, 0, 1);
    drive1(1, 1, 0, 0, 1);
    held = m1.state;
    for (int i = 0; i < 3; i++) drive1(1, 1, 0, 0, 0);
    settle;
    chk("stall_hold", lfsr1, held);
    chk("stall_valid", ovld1, 1);
    for (int i = 0; i < 600; i++)
      drive1(($urandom_range(49) != 0), ($urandom_range(4) != 0), ($urandom_range(9) == 0),
             $urandom_range(15), ($urandom_range(3) != 0));
  endtask

  initial begin
    m0 = '{default: 0};
    m1 = '{default: 0};
    fork
      stim0;
      stim1;
    join
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
